// File: rtl/multi_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : multi_ctrl
//  Purpose  : Multi-cycle MIPS-subset control unit. A 5-bit state register
//             walks each instruction through fetch, decode, execute, memory
//             and write-back steps. All datapath controls are decoded
//             combinationally from the current state, Inst and MIO_ready.
//  Ports    : clk, reset (sync, active-high)
//             Inst[31:0]     instruction register (opcode [31:26], funct [5:0])
//             MIO_ready      memory access completes this cycle
//             zero           ALU zero flag (consumed by the datapath PC enable)
//             MemRead/MemWrite/CPU_MIO, IorD, IRWrite, RegWrite, PCWrite,
//             PCWriteCond, Branch, unsign       1-bit controls
//             RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource   2-bit selects
//             ALU_operation[2:0], state_out[4:0] (debug)
//  Revision : 1.0  initial release
// ============================================================================
module multi_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Inst,
    input  logic        MIO_ready,
    input  logic        zero,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        CPU_MIO,
    output logic        IorD,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        Branch,
    output logic        unsign,
    output logic [1:0]  RegDst,
    output logic [1:0]  MemtoReg,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  PCSource,
    output logic [2:0]  ALU_operation,
    output logic [4:0]  state_out
);

    localparam logic [4:0] S_IF       = 5'd0;
    localparam logic [4:0] S_ID       = 5'd1;
    localparam logic [4:0] S_MEM_ADDR = 5'd2;
    localparam logic [4:0] S_MEM_RD   = 5'd3;
    localparam logic [4:0] S_LW_WB    = 5'd4;
    localparam logic [4:0] S_MEM_WR   = 5'd5;
    localparam logic [4:0] S_R_EXE    = 5'd6;
    localparam logic [4:0] S_ALU_WB   = 5'd7;
    localparam logic [4:0] S_BR       = 5'd8;
    localparam logic [4:0] S_J        = 5'd9;
    localparam logic [4:0] S_I_EXE    = 5'd10;
    localparam logic [4:0] S_LUI_WB   = 5'd11;
    localparam logic [4:0] S_JAL      = 5'd12;
    localparam logic [4:0] S_JR       = 5'd13;
    localparam logic [4:0] S_JALR     = 5'd14;

    localparam logic [5:0] C_OP_RTYPE = 6'h00;
    localparam logic [5:0] C_OP_J     = 6'h02;
    localparam logic [5:0] C_OP_JAL   = 6'h03;
    localparam logic [5:0] C_OP_BEQ   = 6'h04;
    localparam logic [5:0] C_OP_BNE   = 6'h05;
    localparam logic [5:0] C_OP_ADDI  = 6'h08;
    localparam logic [5:0] C_OP_SLTI  = 6'h0A;
    localparam logic [5:0] C_OP_ANDI  = 6'h0C;
    localparam logic [5:0] C_OP_ORI   = 6'h0D;
    localparam logic [5:0] C_OP_XORI  = 6'h0E;
    localparam logic [5:0] C_OP_LUI   = 6'h0F;
    localparam logic [5:0] C_OP_LW    = 6'h23;
    localparam logic [5:0] C_OP_SW    = 6'h2B;

    localparam logic [5:0] C_FN_SRL   = 6'h02;
    localparam logic [5:0] C_FN_JR    = 6'h08;
    localparam logic [5:0] C_FN_JALR  = 6'h09;
    localparam logic [5:0] C_FN_ADD   = 6'h20;
    localparam logic [5:0] C_FN_SUB   = 6'h22;
    localparam logic [5:0] C_FN_AND   = 6'h24;
    localparam logic [5:0] C_FN_OR    = 6'h25;
    localparam logic [5:0] C_FN_XOR   = 6'h26;
    localparam logic [5:0] C_FN_NOR   = 6'h27;
    localparam logic [5:0] C_FN_SLT   = 6'h2A;

    localparam logic [2:0] C_ALU_AND  = 3'b000;
    localparam logic [2:0] C_ALU_OR   = 3'b001;
    localparam logic [2:0] C_ALU_ADD  = 3'b010;
    localparam logic [2:0] C_ALU_XOR  = 3'b011;
    localparam logic [2:0] C_ALU_NOR  = 3'b100;
    localparam logic [2:0] C_ALU_SRL  = 3'b101;
    localparam logic [2:0] C_ALU_SUB  = 3'b110;
    localparam logic [2:0] C_ALU_SLT  = 3'b111;

    logic [4:0] r_state;
    logic [4:0] w_next;
    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic       w_unused;

    assign w_op     = Inst[31:26];
    assign w_funct  = Inst[5:0];
    // Branch resolution (zero == Branch) happens in the datapath PC enable.
    assign w_unused = ^{zero, Inst[25:6]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IF;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        CPU_MIO       = 1'b0;
        IorD          = 1'b0;
        IRWrite       = 1'b0;
        RegWrite      = 1'b0;
        PCWrite       = 1'b0;
        PCWriteCond   = 1'b0;
        Branch        = 1'b0;
        unsign        = 1'b0;
        RegDst        = 2'b00;
        MemtoReg      = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        PCSource      = 2'b00;
        ALU_operation = C_ALU_AND;
        state_out     = 5'd0;
        w_next        = S_IF;
        // Reset masks every output so a stalled access is dropped at once.
        if (!reset) begin
            state_out = r_state;
            case (r_state)
                S_IF: begin
                    MemRead       = 1'b1;
                    CPU_MIO       = 1'b1;
                    IRWrite       = MIO_ready;
                    ALUSrcB       = 2'b01;
                    ALU_operation = C_ALU_ADD;
                    PCWrite       = 1'b1;
                    w_next        = MIO_ready ? S_ID : S_IF;
                end
                S_ID: begin
                    // PC already incremented: ALUOut <= PC + (imm << 2).
                    ALUSrcB       = 2'b11;
                    ALU_operation = C_ALU_ADD;
                    case (w_op)
                        C_OP_LW, C_OP_SW: w_next = S_MEM_ADDR;
                        C_OP_RTYPE: begin
                            case (w_funct)
                                C_FN_JR:   w_next = S_JR;
                                C_FN_JALR: w_next = S_JALR;
                                C_FN_ADD, C_FN_SUB, C_FN_AND, C_FN_OR,
                                C_FN_XOR, C_FN_NOR, C_FN_SLT, C_FN_SRL:
                                           w_next = S_R_EXE;
                                default:   w_next = S_IF;
                            endcase
                        end
                        C_OP_BEQ, C_OP_BNE: w_next = S_BR;
                        C_OP_J:             w_next = S_J;
                        C_OP_JAL:           w_next = S_JAL;
                        C_OP_ADDI, C_OP_ANDI, C_OP_ORI, C_OP_XORI, C_OP_SLTI:
                                            w_next = S_I_EXE;
                        C_OP_LUI:           w_next = S_LUI_WB;
                        default:            w_next = S_IF;
                    endcase
                end
                S_MEM_ADDR: begin
                    ALUSrcA       = 2'b01;
                    ALUSrcB       = 2'b10;
                    ALU_operation = C_ALU_ADD;
                    w_next        = (w_op == C_OP_LW) ? S_MEM_RD : S_MEM_WR;
                end
                S_MEM_RD: begin
                    IorD    = 1'b1;
                    MemRead = 1'b1;
                    CPU_MIO = 1'b1;
                    w_next  = MIO_ready ? S_LW_WB : S_MEM_RD;
                end
                S_LW_WB: begin
                    MemtoReg = 2'b01;
                    RegWrite = 1'b1;
                end
                S_MEM_WR: begin
                    IorD     = 1'b1;
                    MemWrite = 1'b1;
                    CPU_MIO  = 1'b1;
                    w_next   = MIO_ready ? S_IF : S_MEM_WR;
                end
                S_R_EXE: begin
                    ALUSrcA = (w_funct == C_FN_SRL) ? 2'b10 : 2'b01;
                    case (w_funct)
                        C_FN_SUB: ALU_operation = C_ALU_SUB;
                        C_FN_AND: ALU_operation = C_ALU_AND;
                        C_FN_OR:  ALU_operation = C_ALU_OR;
                        C_FN_XOR: ALU_operation = C_ALU_XOR;
                        C_FN_NOR: ALU_operation = C_ALU_NOR;
                        C_FN_SLT: ALU_operation = C_ALU_SLT;
                        C_FN_SRL: ALU_operation = C_ALU_SRL;
                        default:  ALU_operation = C_ALU_ADD;
                    endcase
                    w_next = S_ALU_WB;
                end
                S_ALU_WB: begin
                    // Shared by R-type (dest rd) and I-type (dest rt).
                    RegDst   = (w_op == C_OP_RTYPE) ? 2'b01 : 2'b00;
                    RegWrite = 1'b1;
                end
                S_BR: begin
                    ALUSrcA       = 2'b01;
                    ALU_operation = C_ALU_SUB;
                    PCSource      = 2'b01;
                    PCWriteCond   = 1'b1;
                    Branch        = (w_op == C_OP_BEQ);
                end
                S_J: begin
                    PCSource = 2'b10;
                    PCWrite  = 1'b1;
                end
                S_I_EXE: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b10;
                    case (w_op)
                        C_OP_ANDI: ALU_operation = C_ALU_AND;
                        C_OP_ORI:  ALU_operation = C_ALU_OR;
                        C_OP_XORI: ALU_operation = C_ALU_XOR;
                        C_OP_SLTI: ALU_operation = C_ALU_SLT;
                        default:   ALU_operation = C_ALU_ADD;
                    endcase
                    unsign = (w_op == C_OP_ANDI) || (w_op == C_OP_ORI) ||
                             (w_op == C_OP_XORI);
                    w_next = S_ALU_WB;
                end
                S_LUI_WB: begin
                    MemtoReg = 2'b10;
                    RegWrite = 1'b1;
                end
                S_JAL: begin
                    PCSource = 2'b10;
                    PCWrite  = 1'b1;
                    RegDst   = 2'b10;
                    MemtoReg = 2'b11;
                    RegWrite = 1'b1;
                end
                S_JR: begin
                    PCSource = 2'b11;
                    PCWrite  = 1'b1;
                end
                S_JALR: begin
                    PCSource = 2'b11;
                    PCWrite  = 1'b1;
                    RegDst   = 2'b01;
                    MemtoReg = 2'b11;
                    RegWrite = 1'b1;
                end
                default: w_next = S_IF;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multi_ctrl
//  Purpose  : Self-checking bench for multi_ctrl. A stimulus process walks
//             instructions through their expected step lists, pushing the
//             expected control vector per cycle into a queue; a monitor on
//             the falling edge pops and compares against the DUT outputs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_multi_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] Inst;
    logic        MIO_ready;
    logic        zero;
    logic        MemRead, MemWrite, CPU_MIO, IorD, IRWrite, RegWrite;
    logic        PCWrite, PCWriteCond, Branch, unsign;
    logic [1:0]  RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource;
    logic [2:0]  ALU_operation;
    logic [4:0]  state_out;

    multi_ctrl dut (
        .clk(clk), .reset(reset), .Inst(Inst), .MIO_ready(MIO_ready),
        .zero(zero), .MemRead(MemRead), .MemWrite(MemWrite),
        .CPU_MIO(CPU_MIO), .IorD(IorD), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
        .Branch(Branch), .unsign(unsign), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .PCSource(PCSource), .ALU_operation(ALU_operation),
        .state_out(state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [27:0] exp_q[$];
    int          tag_q[$];
    int          seq_q[$];
    int          n_vec;
    int          n_bad;

    // Expected controls for one step, written straight from the state table.
    // Packing: {MemRead,MemWrite,CPU_MIO,IorD,IRWrite,RegWrite,PCWrite,
    //           PCWriteCond,Branch,unsign,RegDst,MemtoReg,ALUSrcA,ALUSrcB,
    //           PCSource,ALU_operation,state_out}
    function automatic logic [27:0] exp_out(input int st, input logic [31:0] ins,
                                            input logic mio);
        logic mr, mw, mio_o, iord, irw, rw, pcw, pcc, br, uns;
        logic [1:0] rd, m2r, sa, sb, pcs;
        logic [2:0] alu;
        logic [5:0] op, fn;
        op = ins[31:26]; fn = ins[5:0];
        {mr, mw, mio_o, iord, irw, rw, pcw, pcc, br, uns} = '0;
        {rd, m2r, sa, sb, pcs} = '0;
        alu = 3'b000;
        case (st)
            0:  begin mr = 1; mio_o = 1; irw = mio; sb = 2'b01; alu = 3'b010; pcw = 1; end
            1:  begin sb = 2'b11; alu = 3'b010; end
            2:  begin sa = 2'b01; sb = 2'b10; alu = 3'b010; end
            3:  begin iord = 1; mr = 1; mio_o = 1; end
            4:  begin m2r = 2'b01; rw = 1; end
            5:  begin iord = 1; mw = 1; mio_o = 1; end
            6:  begin
                    sa = (fn == 6'h02) ? 2'b10 : 2'b01;
                    case (fn)
                        6'h20: alu = 3'b010; 6'h22: alu = 3'b110;
                        6'h24: alu = 3'b000; 6'h25: alu = 3'b001;
                        6'h26: alu = 3'b011; 6'h27: alu = 3'b100;
                        6'h2A: alu = 3'b111; 6'h02: alu = 3'b101;
                        default: alu = 3'bxxx;
                    endcase
                end
            7:  begin rd = (op == 6'h00) ? 2'b01 : 2'b00; rw = 1; end
            8:  begin sa = 2'b01; alu = 3'b110; pcs = 2'b01; pcc = 1; br = (op == 6'h04); end
            9:  begin pcs = 2'b10; pcw = 1; end
            10: begin
                    sa = 2'b01; sb = 2'b10;
                    case (op)
                        6'h08: alu = 3'b010; 6'h0C: alu = 3'b000;
                        6'h0D: alu = 3'b001; 6'h0E: alu = 3'b011;
                        default: alu = 3'b111;
                    endcase
                    uns = (op == 6'h0C) || (op == 6'h0D) || (op == 6'h0E);
                end
            11: begin m2r = 2'b10; rw = 1; end
            12: begin pcs = 2'b10; pcw = 1; rd = 2'b10; m2r = 2'b11; rw = 1; end
            13: begin pcs = 2'b11; pcw = 1; end
            14: begin pcs = 2'b11; pcw = 1; rd = 2'b01; m2r = 2'b11; rw = 1; end
            default: ;
        endcase
        return {mr, mw, mio_o, iord, irw, rw, pcw, pcc, br, uns,
                rd, m2r, sa, sb, pcs, alu, st[4:0]};
    endfunction

    // Step list that follows IF for a given instruction.
    task automatic build_seq(input logic [31:0] ins);
        logic [5:0] op, fn;
        op = ins[31:26]; fn = ins[5:0];
        seq_q.delete();
        seq_q.push_back(1);
        case (op)
            6'h23: begin seq_q.push_back(2); seq_q.push_back(3); seq_q.push_back(4); end
            6'h2B: begin seq_q.push_back(2); seq_q.push_back(5); end
            6'h00: begin
                if (fn == 6'h08) seq_q.push_back(13);
                else if (fn == 6'h09) seq_q.push_back(14);
                else if (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h02}) begin
                    seq_q.push_back(6); seq_q.push_back(7);
                end
            end
            6'h04, 6'h05: seq_q.push_back(8);
            6'h02: seq_q.push_back(9);
            6'h03: seq_q.push_back(12);
            6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0A: begin seq_q.push_back(10); seq_q.push_back(7); end
            6'h0F: seq_q.push_back(11);
            default: ;
        endcase
    endtask

    // Drive one cycle of inputs and record what the DUT must show for it.
    task automatic apply(input int st, input logic [31:0] ins, input logic mio,
                         input logic rst);
        @(posedge clk); #1;
        Inst = ins; MIO_ready = mio; reset = rst; zero = 1'($urandom);
        exp_q.push_back(rst ? 28'd0 : exp_out(st, ins, mio));
        tag_q.push_back(rst ? -1 : st);
    endtask

    // forced: memory-stall cycles before ready; rst_mem: reset inside that
    // stall; rnd: random ready levels and occasional random reset aborts.
    task automatic run_instr(input logic [31:0] ins, input int forced,
                             input bit rst_mem, input bit rnd);
        logic mio;
        build_seq(ins);
        do begin
            mio = rnd ? (($urandom % 3) != 0) : 1'b1;
            apply(0, ins, mio, 1'b0);
        end while (!mio);
        for (int i = 0; i < seq_q.size(); i++) begin
            int st;
            st = seq_q[i];
            if (rnd && ($urandom % 25) == 0) begin
                apply(st, ins, 1'($urandom), 1'b1);
                return;
            end
            if (st == 3 || st == 5) begin
                int k;
                k = 0;
                forever begin
                    if (rst_mem && k == forced) begin
                        apply(st, ins, 1'b0, 1'b1);
                        return;
                    end
                    mio = (k < forced) ? 1'b0 : (rnd ? (($urandom % 3) != 0) : 1'b1);
                    apply(st, ins, mio, 1'b0);
                    k++;
                    if (mio) break;
                end
            end else begin
                apply(st, ins, 1'($urandom), 1'b0);
            end
        end
    endtask

    logic [27:0] mon_e, mon_a;
    int          mon_t;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_t = tag_q.pop_front();
            mon_a = {MemRead, MemWrite, CPU_MIO, IorD, IRWrite, RegWrite, PCWrite,
                     PCWriteCond, Branch, unsign, RegDst, MemtoReg, ALUSrcA,
                     ALUSrcB, PCSource, ALU_operation, state_out};
            n_vec++;
            if (mon_a !== mon_e) begin
                n_bad++;
                $display("FAIL step_%0d inst=%h: got %h expected %h (t=%0t)",
                         mon_t, Inst, mon_a, mon_e, $time);
            end
        end
    end

    function automatic logic [31:0] rand_inst();
        logic [5:0] ops[15];
        logic [5:0] fns[11];
        logic [31:0] r;
        ops = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02,
                6'h03, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h0F};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h02,
                6'h08, 6'h09, 6'h3F};
        r = $urandom;
        if (($urandom % 12) == 0) r[31:26] = 6'h3F;
        else r[31:26] = ops[$urandom % 15];
        if (r[31:26] == 6'h00) r[5:0] = fns[$urandom % 11];
        return r;
    endfunction

    initial begin
        n_vec = 0; n_bad = 0;
        reset = 1'b1; Inst = 32'd0; MIO_ready = 1'b0; zero = 1'b0;
        apply(0, 32'd0, 1'b0, 1'b1);
        apply(0, 32'd0, 1'b1, 1'b1);
        run_instr(32'h00221820, 0, 1'b0, 1'b0); // add
        run_instr(32'h8C220004, 3, 1'b0, 1'b0); // lw, 3 stall cycles
        run_instr(32'h10220003, 0, 1'b0, 1'b0); // beq
        run_instr(32'h14220003, 0, 1'b0, 1'b0); // bne
        run_instr(32'h0C000010, 0, 1'b0, 1'b0); // jal
        run_instr(32'hFC000000, 0, 1'b0, 1'b0); // illegal opcode
        run_instr(32'hAC220004, 2, 1'b1, 1'b0); // sw, reset mid-stall
        run_instr(32'hAC220004, 1, 1'b0, 1'b0); // sw completes
        run_instr(32'h08000004, 0, 1'b0, 1'b0); // j
        run_instr(32'h00200008, 0, 1'b0, 1'b0); // jr
        run_instr(32'h0020F809, 0, 1'b0, 1'b0); // jalr
        run_instr(32'h3C011234, 0, 1'b0, 1'b0); // lui
        run_instr(32'h30220FF0, 0, 1'b0, 1'b0); // andi
        run_instr(32'h00021842, 0, 1'b0, 1'b0); // srl
        run_instr(32'h0000003F, 0, 1'b0, 1'b0); // illegal funct
        run_instr(32'h8C220004, 2, 1'b1, 1'b0); // lw, reset mid-stall
        for (int n = 0; n < 400; n++) begin
            int f;
            f = int'($urandom % 4);
            run_instr(rand_inst(), f, (f > 0) && (($urandom % 6) == 0), 1'b1);
        end
        @(posedge clk);
        @(negedge clk); #1;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multi_ctrl.md
MULTI_CTRL -- requirements
Module: multi_ctrl

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 Inst  input  32  current instruction-register contents; opcode Inst[31:26], funct Inst[5:0].
REQ-004 MIO_ready  input  1  memory ready; 1 = this cycle's access completes.
REQ-005 zero  input  1  ALU zero flag from datapath.
REQ-006 MemRead, MemWrite, CPU_MIO  output  1 each  memory read strobe, write strobe, memory-access-in-progress.
REQ-007 IorD, IRWrite, RegWrite, PCWrite, PCWriteCond, Branch, unsign  output  1 each  datapath controls.
REQ-008 RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource  output  2 each  datapath mux selects.
REQ-009 ALU_operation  output  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 100 NOR, 101 SRL, 011 XOR.
REQ-010 state_out  output  5  current state code, for debug.

Function
REQ-011 Mux encodings SHALL be: ALUSrcA 00 PC, 01 rs, 10 shamt, 11 zero; ALUSrcB 00 rt, 01 const 4, 10 ext imm, 11 ext imm<<2; PCSource 00 ALU result, 01 ALUOut, 10 jump target, 11 rs; MemtoReg 00 ALUOut, 01 MDR, 10 {imm,16'h0}, 11 PC; RegDst 00 rt, 01 rd, 10 r31.
REQ-012 Datapath PC enable = MIO_ready & (PCWrite | PCWriteCond & (zero == Branch)); the FSM SHALL rely on this and never drive PCWrite and PCWriteCond together.
REQ-013 States (code): IF 0, ID 1, MEM_ADDR 2, MEM_RD 3, LW_WB 4, MEM_WR 5, R_EXE 6, ALU_WB 7, BR 8, J 9, I_EXE 10, LUI_WB 11, JAL 12, JR 13, JALR 14; state register 5 bits; other codes SHALL go to IF.
REQ-014 Outputs SHALL be combinational from state, Inst and MIO_ready; any signal not listed for a state is 0.
REQ-015 IF: IorD=0, MemRead=1, CPU_MIO=1, IRWrite=MIO_ready, ALUSrcA=00, ALUSrcB=01, ADD, PCSource=00, PCWrite=1; stays in IF while MIO_ready=0, else goes to ID.
REQ-016 ID: ALUSrcA=00, ALUSrcB=11, ADD, so ALUOut = branch target. Next state by decode: lw/sw -> MEM_ADDR; R-type -> R_EXE, except jr(funct 001000) -> JR and jalr(001001) -> JALR; beq/bne -> BR; j -> J; jal -> JAL; addi/andi/ori/xori/slti -> I_EXE; lui -> LUI_WB; any other opcode or R funct -> IF with no writes.
REQ-017 MEM_ADDR: ALUSrcA=01, ALUSrcB=10, ADD, unsign=0; next MEM_RD (lw) or MEM_WR (sw).
REQ-018 MEM_RD: IorD=1, MemRead=1, CPU_MIO=1; holds until MIO_ready=1, then LW_WB. LW_WB: RegDst=00, MemtoReg=01, RegWrite=1; next IF.
REQ-019 MEM_WR: IorD=1, MemWrite=1, CPU_MIO=1; holds until MIO_ready=1, then IF.
REQ-020 R_EXE: ALUSrcA=01 (10 for srl), ALUSrcB=00, ALU_operation from funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101010 SLT, 000010 SRL. Next ALU_WB: RegDst=01, MemtoReg=00, RegWrite=1; next IF.
REQ-021 I_EXE: ALUSrcA=01, ALUSrcB=10; addi ADD, andi AND, ori OR, xori XOR, slti SLT; unsign=1 for andi/ori/xori, else 0. Next ALU_WB with RegDst=00 for I-type.
REQ-022 BR: ALUSrcA=01, ALUSrcB=00, SUB, PCSource=01, PCWriteCond=1, Branch=1 for beq / 0 for bne; next IF.
REQ-023 J: PCSource=10, PCWrite=1. JAL: same plus RegDst=10, MemtoReg=11, RegWrite=1 (writes already-incremented PC). JR: PCSource=11, PCWrite=1. JALR: PCSource=11, PCWrite=1, RegDst=01, MemtoReg=11, RegWrite=1. All next IF.
REQ-024 Non-IF/non-memory states SHALL advance unconditionally; MIO_ready low only stalls IF, MEM_RD, MEM_WR.

Reset
REQ-025 On a clk edge with reset=1 the state SHALL become IF; while reset=1 every output SHALL be 0 (state_out = 0).
REQ-026 Reset asserted in any state, including a stalled MEM_RD/MEM_WR, SHALL abort the instruction with no further RegWrite/MemWrite/PCWrite.

Verification
REQ-027 Reset, then Inst=add $3,$1,$2 (0x00221820), MIO_ready=1 -> states 0,1,6,7,0; RegWrite=1 only in 7 with RegDst=01.
REQ-028 lw (0x8C220004) with MIO_ready=0 for 3 cycles in MEM_RD -> state_out holds 3 for 3 cycles, then 4 with MemtoReg=01, RegWrite=1.
REQ-029 beq (0x10220003) -> BR state: PCWriteCond=1, Branch=1, ALU_operation=110, PCSource=01; bne (0x14220003) -> Branch=0.
REQ-030 jal (0x0C000010) -> JAL: PCWrite=1, PCSource=10, RegDst=10, MemtoReg=11, RegWrite=1; next IF.
REQ-031 Opcode 0x3F -> ID returns to IF; no write enable asserted at any point.
REQ-032 Reset pulsed during MEM_WR stall -> next state_out=0, MemWrite=0 while reset high.
